// File: rtl/chnl_tx_hdr.sv
// rtl/chnl_tx_hdr.sv - buffered RIFFA TX channel with per-transaction header, idle timeout and flush
//
// Ports:
//   clk, rst_n              single clock (also CHNL_TX_CLK), asynchronous active-low reset
//   cfg_idle_cycles         idle timeout in cycles, 0 disables the timeout
//   flush                   flush request pulse, held internally until serviced
//   i_val/i_rdy/i_data      user input stream, TX_WIDTH bits per word
//   CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
//   CHNL_TX_DATA, CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN
//                           RIFFA TX channel, W = C_PCI_DATA_WIDTH data bits
//   o_seq                   count of completed transactions, wraps at 2^32
module chnl_tx_hdr #(
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int TX_WIDTH         = 64,
  parameter int GCD              = 64,
  parameter int CHNL_ALIGN       = 4,
  parameter int MAX_LENGTH       = 16384,
  parameter int HDR_EN           = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 cfg_idle_cycles,
  input  logic                        flush,
  input  logic                        i_val,
  output logic                        i_rdy,
  input  logic [TX_WIDTH-1:0]         i_data,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  output logic [31:0]                 o_seq
);
  localparam int W     = C_PCI_DATA_WIDTH;
  localparam int LANES = W / 32;
  // The input stage gathers W/TX_WIDTH user words (lane 0 first) into one beat.
  localparam int RATIO = W / TX_WIDTH;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ALIGN = 32 * CHNL_ALIGN / W;
  localparam int P_MAX = (MAX_LENGTH - HDR_EN * CHNL_ALIGN) * 32 / W;
  // FIFO holds a full committed transaction plus at least as many queued beats.
  localparam int AW    = $clog2(P_MAX) + 1;
  localparam logic [31:0] ALIGN_L   = 32'(ALIGN);
  localparam logic [31:0] P_MAX_L   = 32'(P_MAX);
  localparam logic [31:0] HDR_BEATS = 32'(HDR_EN * ALIGN);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
  state_t state, state_nx;

  logic [W-1:0]  pk_d;
  logic [PW-1:0] pk_cnt;
  logic          pk_v, pk_last, in_acc, push, pop;
  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   f_cnt;
  logic          fifo_full, fifo_val;
  logic [W-1:0]  fifo_head, hdr_beat, tx_data;
  logic [31:0]   q, n_align, n_sel, n_cur, cnt, len_r, seq, hk;
  logic [15:0]   idle;
  logic [2:0]    flags_sel, flags;
  logic          flush_l, clr_flush, go, tx_valid, accept, last_acc;
  logic          unused_ok;

  assign unused_ok = CHNL_TX_ACK ^ (GCD == 0);

  // Input buffer + repacker: one staging beat; it stalls only on a full FIFO.
  assign i_rdy   = rst_n & (~pk_v | ~fifo_full);
  assign in_acc  = i_val & i_rdy;
  assign pk_last = (pk_cnt == PW'(RATIO - 1));
  assign push    = pk_v & ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_v   <= 1'b0;
      pk_cnt <= '0;
      pk_d   <= '0;
    end else begin
      if (in_acc) begin
        for (int r = 0; r < RATIO; r++)
          if (pk_cnt == PW'(r)) pk_d[r*TX_WIDTH +: TX_WIDTH] <= i_data;
        pk_cnt <= pk_last ? '0 : pk_cnt + 1'b1;
      end
      pk_v <= (pk_v & ~push) | (in_acc & pk_last);
    end
  end

  // Beat FIFO
  assign fifo_full = f_cnt[AW];
  assign fifo_val  = |f_cnt;
  assign fifo_head = mem[rd_ptr];
  assign pop       = (state == S_DATA) & CHNL_TX_DATA_REN & fifo_val;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pk_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      f_cnt  <= f_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Trigger selection, only meaningful in S_IDLE; full beats flush beats timeout.
  always_comb begin
    n_align   = q - (q % ALIGN_L);
    go        = 1'b0;
    clr_flush = 1'b0;
    n_sel     = '0;
    flags_sel = '0;
    if (state == S_IDLE) begin
      if (q >= P_MAX_L) begin
        go        = 1'b1;
        n_sel     = P_MAX_L;
        flags_sel = 3'd4;
      end else if (flush_l) begin
        clr_flush = 1'b1;
        n_sel     = n_align;
        flags_sel = 3'd2;
        // With no header an empty flush has nothing to send and is dropped.
        go        = (n_align != 32'd0) || (HDR_EN != 0);
      end else if (cfg_idle_cycles != 16'd0 && idle >= cfg_idle_cycles && q >= ALIGN_L) begin
        go        = 1'b1;
        n_sel     = n_align;
        flags_sel = 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      idle    <= '0;
      flush_l <= 1'b0;
    end else begin
      q       <= q + {31'b0, push} - (go ? n_sel : 32'd0);
      flush_l <= (flush_l & ~clr_flush) | flush;
      if (push)                         idle <= '0;
      else if (idle < cfg_idle_cycles)  idle <= idle + 16'd1;
    end
  end

  // Header beat for the current beat index: {seq, payload uint32 count, flags, 0...}
  always_comb begin
    hdr_beat = '0;
    hk       = '0;
    for (int l = 0; l < LANES; l++) begin
      hk = cnt * 32'(LANES) + 32'(l);
      if (hk == 32'd0)      hdr_beat[l*32 +: 32] = seq;
      else if (hk == 32'd1) hdr_beat[l*32 +: 32] = n_cur * 32'(LANES);
      else if (hk == 32'd2) hdr_beat[l*32 +: 32] = {29'b0, flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (state)
      S_IDLE: if (go) state_nx = (HDR_EN != 0) ? S_HDR : S_DATA;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_beat;
        if (CHNL_TX_DATA_REN && cnt == ALIGN_L - 32'd1)
          state_nx = (n_cur == 32'd0) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        tx_valid = fifo_val;
        tx_data  = fifo_head;
        if (fifo_val && CHNL_TX_DATA_REN && cnt == n_cur - 32'd1) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept   = tx_valid & CHNL_TX_DATA_REN;
  assign last_acc = accept & (state_nx == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      n_cur <= '0;
      flags <= '0;
      len_r <= '0;
      seq   <= '0;
    end else begin
      if (go) begin
        cnt   <= '0;
        n_cur <= n_sel;
        flags <= flags_sel;
        len_r <= (n_sel + HDR_BEATS) * 32'(LANES);
      end else if (accept) begin
        cnt <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
      end
      if (last_acc) seq <= seq + 32'd1;
    end
  end

  assign CHNL_TX            = (state != S_IDLE);
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_LEN        = len_r;
  assign CHNL_TX_DATA       = tx_data;
  assign CHNL_TX_DATA_VALID = tx_valid;
  assign o_seq              = seq;
endmodule

// File: doc/chnl_tx_hdr.md
# chnl_tx_hdr

Buffered RIFFA/CHNL transmitter that adds an optional per-transaction header, a runtime idle timeout and an explicit flush request. It sits between a user stream (val/rdy) and one RIFFA TX channel, reusing the `buffer`, `repacker` and `deep_fifo` blocks. Host software can recover the sequence, length and trigger cause of each `fpga_recv` from the header alone.

## Interface
- `C_PCI_DATA_WIDTH`, 64: PCIe data width.
  - ≥32, multiple of 32.
  - W below.
- `TX_WIDTH`, 64: user input width.
- `GCD`, 64: gcd(`TX_WIDTH`, W).
- `CHNL_ALIGN`, 4: transaction granularity, in uint32.
  - ≥ W/32.
  - ≥3 when `HDR_EN`=1.
  - ALIGN = 32·`CHNL_ALIGN`/W beats.
- `MAX_LENGTH`, 16384: maximum transaction length, in uint32, including the header.
  - Must be a multiple of `CHNL_ALIGN`.
  - Must be > `CHNL_ALIGN`.
- `HDR_EN`, 1: 1 prepends a header unit of `CHNL_ALIGN` uint32 to every transaction.
- `clk` input 1: single clock. `CHNL_TX_CLK` = `clk`.
- `rst_n` input 1: asynchronous, active-low reset.
  - Submodules receive `~rst_n`.
- `cfg_idle_cycles` input 16: idle timeout in cycles. 0 disables the timeout.
- `flush` input 1: flush request pulse, latched (sticky) until serviced.
- `i_val`/`i_rdy`/`i_data[TX_WIDTH-1:0]`: user stream, standard val/rdy.
- `CHNL_TX` output 1, `CHNL_TX_ACK` input 1, `CHNL_TX_LAST` output 1 (tied 1), `CHNL_TX_LEN` output 32, `CHNL_TX_OFF` output 31 (tied 0).
- `CHNL_TX_DATA` output W, `CHNL_TX_DATA_VALID` output 1, `CHNL_TX_DATA_REN` input 1.
- `o_seq` output 32: count of completed transactions; wraps at 2^32.

## Operation
**Queue tracking**
- `q`: 32-bit count of beats in the FIFO not yet committed to a transaction.
  - +1 on each FIFO push.
  - −N at a trigger, where N is the committed beat count.
  - Both may occur in the same cycle.
- `idle`: 16-bit counter.
  - Cleared on a FIFO push.
  - Otherwise increments, saturating at `cfg_idle_cycles`.
- P_MAX = (`MAX_LENGTH` − `HDR_EN`·`CHNL_ALIGN`)·32/W beats.

**States**
- S_IDLE → S_HDR (`HDR_EN`=1) or S_DATA (`HDR_EN`=0) when a trigger fires.
- S_HDR → S_DATA after ALIGN accepted header beats. S_HDR → S_IDLE instead if N = 0.
- S_DATA → S_IDLE after N accepted beats.

**Triggers** (evaluated in S_IDLE only; first match wins)
1. Full: q ≥ P_MAX.
   - N = P_MAX, flags = 4.
2. Flush latched:
   - N = q − (q mod ALIGN), flags = 2.
   - If N = 0 and `HDR_EN`=1: a header-only transaction is sent.
   - If N = 0 and `HDR_EN`=0: the request is dropped.
   - In every case the flush latch clears.
3. Timeout: `cfg_idle_cycles` ≠ 0, `idle` ≥ `cfg_idle_cycles`, and q ≥ ALIGN.
   - N = q − (q mod ALIGN), flags = 1.

A full trigger that coincides with a latched flush leaves the flush latched for the next transaction.

**Length and header**
- `CHNL_TX_LEN` = (N + `HDR_EN`·ALIGN)·W/32. It is latched at the trigger and stable while `CHNL_TX`=1.
- Header uint32 fields:
  - Word 0 = `o_seq`.
  - Word 1 = N·W/32, the payload length in uint32.
  - Word 2 = flags.
  - Remaining words = 0.
- Header layout: uint32 k is placed in beat k/(W/32), lane k mod (W/32). Lane 0 is bits [31:0].
- Beat source:
  - In S_HDR, `CHNL_TX_DATA` is the header beat.
  - In S_DATA, `CHNL_TX_DATA` is the FIFO head, and FIFO `o_rdy` = `CHNL_TX_DATA_REN`.
- `o_seq` increments at the cycle the last beat of a transaction is accepted.
- Data order is preserved end to end. The residual q mod ALIGN beats stay queued for a later transaction.

## Timing
- **Reset** (`rst_n`=0): immediate and asynchronous.
  - `CHNL_TX`=0, `CHNL_TX_DATA_VALID`=0, `CHNL_TX_LEN`=0, `o_seq`=0.
  - State S_IDLE; q, `idle` and the flush latch are cleared; FIFO, repacker and buffer are emptied.
  - `i_rdy`=0 while in reset.
  - Reset mid-transaction abandons that transaction without completing it.
- **Transaction start:** trigger in cycle T → `CHNL_TX`=1 with a valid `CHNL_TX_LEN` from T+1.
  - The first header beat is presented at T+1 with `CHNL_TX_DATA_VALID`=1.
- **Beat acceptance:** a beat is accepted when `CHNL_TX_DATA_VALID` && `CHNL_TX_DATA_REN`.
  - `CHNL_TX_DATA_VALID` = 1 in S_HDR; = FIFO `o_val` in S_DATA; = 0 in S_IDLE.
- **Transaction end:** last beat accepted in cycle L → `CHNL_TX`=0 and state S_IDLE at L+1.
  - Earliest next `CHNL_TX` rise is L+2.
- `CHNL_TX` never drops mid-transaction, regardless of `CHNL_TX_ACK` or `CHNL_TX_DATA_REN`.
- A flush pulse arriving while not in S_IDLE is latched and serviced at the next S_IDLE evaluation.
- Input path: `i_rdy` deasserts only when the FIFO is full. Input latency to the FIFO is that of `buffer` plus `repacker`.

## Test plan
- **Timeout:** W=64, `CHNL_ALIGN`=4, `HDR_EN`=1, `cfg_idle_cycles`=8. Push 5 beats, then idle → after 8 idle cycles:
  - LEN=12.
  - Header {0, 8, 1}, followed by 4 payload beats.
  - q=1 afterwards; `o_seq`=1.
- **Flush, header only:** then pulse `flush` with q=1 → header-only transaction:
  - LEN=4, header {1, 0, 2}.
  - q remains 1; `o_seq`=2.
- **Full:** `MAX_LENGTH`=64, continuous input, REN=1 → repeated transactions:
  - LEN=64, flags=4, 30 payload beats each.
  - Payload matches an incrementing input pattern with no gaps or duplicates.
- **Backpressure:** random REN with 50% duty during the full test:
  - `CHNL_TX` held high throughout.
  - VALID only in send states.
  - Data identical to the REN=1 run.
- **No header, flush:** `HDR_EN`=0, `cfg_idle_cycles`=0, push 3 beats, wait 1000 cycles → no transaction. Then `flush`:
  - LEN=4 (2 beats).
  - q=1 afterwards.
  - A second `flush` is dropped with no transaction.
- **Reset mid-transaction:** assert `rst_n`=0 mid-S_DATA:
  - `CHNL_TX`, VALID and `o_seq` read 0 in the same cycle.
  - After release, 2 fresh beats plus timeout send LEN=8 with header seq 0.
